// File: rtl/rf_write_arbiter_pkg.sv
// Shared constants and encodings for the register-file write arbiter.
package rf_write_arbiter_pkg;

  localparam int RF_DATA_W = 16;
  localparam int RF_ADDR_W = 3;
  localparam int RF_NREG   = 1 << RF_ADDR_W;

  // Bit positions of the writeback and load requesters in req/gnt vectors
  localparam int GNT_WB = 0;
  localparam int GNT_LD = 1;

  // Which requester owned the port on the most recent real grant
  typedef enum logic {
    SRC_WB = 1'b0,
    SRC_LD = 1'b1
  } src_e;

endpackage

// File: rtl/rf_write_arbiter_rr_arb2.sv
// Two-way arbiter: round-robin between wb and ld, or fixed wb priority.
module rr_arb2
  import rf_write_arbiter_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  src_e last_grant;

  // Pick a winner from the live requests; on conflict favour whoever did not win last
  always_comb begin
    gnt = 2'b00;
    if (req[GNT_WB] && req[GNT_LD]) begin
      if ((FIXED_PRIO != 0) || (last_grant == SRC_LD))
        gnt[GNT_WB] = 1'b1;
      else
        gnt[GNT_LD] = 1'b1;
    end else begin
      gnt = req;
    end
  end

  // Remember the owner of the last real port grant
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      last_grant <= SRC_WB;
    else if (gnt[GNT_LD])
      last_grant <= SRC_LD;
    else if (gnt[GNT_WB])
      last_grant <= SRC_WB;
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between writeback and late load returns,
// tracking outstanding loads per register and cancelling loads overtaken by a younger wb.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int DATA_W     = RF_DATA_W,
  parameter int ADDR_W     = RF_ADDR_W,
  parameter int FIXED_PRIO = 0,
  parameter int DROP_R0    = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wb_valid,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  output logic                     wb_ready,
  input  logic                     ld_issue_valid,
  input  logic [ADDR_W-1:0]        ld_issue_addr,
  output logic                     ld_issue_ready,
  input  logic                     ld_valid,
  input  logic [ADDR_W-1:0]        ld_addr,
  input  logic [DATA_W-1:0]        ld_data,
  output logic                     ld_ready,
  output logic [(1<<ADDR_W)-1:0]   busy,
  output logic                     rf_write_en,
  output logic [ADDR_W-1:0]        rf_write_address,
  output logic [DATA_W-1:0]        rf_write_data
);

  localparam int NREG = 1 << ADDR_W;

  logic [NREG-1:0]   pend;
  logic [NREG-1:0]   kill;
  logic [NREG-1:0]   pend_nxt;
  logic [NREG-1:0]   kill_nxt;
  logic              ld_kill_hit;
  logic [1:0]        req;
  logic [1:0]        gnt;
  logic [ADDR_W-1:0] wr_addr_p0;
  logic [DATA_W-1:0] wr_data_p0;
  logic              wr_drop_p0;
  logic              out_is_ld_p1;

  // A return is dropped if its load was cancelled earlier or is overtaken this very cycle
  assign ld_kill_hit = kill[ld_addr] |
                       (wb_valid & (wb_addr == ld_addr) & pend[ld_addr]);

  // Killed returns never compete for the port
  assign req[GNT_WB] = wb_valid;
  assign req[GNT_LD] = ld_valid & ~ld_kill_hit;

  rr_arb2 #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_arb (
    .clock (clock),
    .reset (reset),
    .req   (req),
    .gnt   (gnt)
  );

  assign wb_ready       = gnt[GNT_WB];
  assign ld_ready       = gnt[GNT_LD] | ld_kill_hit;
  assign ld_issue_ready = ~busy[ld_issue_addr];

  // Hazard flags also cover the cycle in which load data is still on its way into the regfile
  always_comb begin
    busy = '0;
    for (int i = 0; i < NREG; i++)
      busy[i] = pend[i] |
                (rf_write_en & out_is_ld_p1 & (rf_write_address == ADDR_W'(i)));
  end

  // Next pend/kill: WAW cancel, then return clear, then new issue (issue wins the same register)
  always_comb begin
    pend_nxt = pend;
    kill_nxt = kill;
    if (wb_valid && wb_ready && pend[wb_addr])
      kill_nxt[wb_addr] = 1'b1;
    if (ld_valid && ld_ready) begin
      pend_nxt[ld_addr] = 1'b0;
      kill_nxt[ld_addr] = 1'b0;
    end
    if (ld_issue_valid && ld_issue_ready) begin
      pend_nxt[ld_issue_addr] = 1'b1;
      kill_nxt[ld_issue_addr] = 1'b0;
    end
  end

  // Outstanding-load bookkeeping
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend <= '0;
      kill <= '0;
    end else begin
      pend <= pend_nxt;
      kill <= kill_nxt;
    end
  end

  // Stage p0: select the granted write
  assign wr_addr_p0 = gnt[GNT_LD] ? ld_addr : wb_addr;
  assign wr_data_p0 = gnt[GNT_LD] ? ld_data : wb_data;
  assign wr_drop_p0 = (DROP_R0 != 0) && (wr_addr_p0 == '0);

  // Stage p1: registered regfile write port
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rf_write_en      <= 1'b0;
      rf_write_address <= '0;
      rf_write_data    <= '0;
      out_is_ld_p1     <= 1'b0;
    end else begin
      rf_write_en  <= (|gnt) & ~wr_drop_p0;
      out_is_ld_p1 <= gnt[GNT_LD];
      if (|gnt) begin
        rf_write_address <= wr_addr_p0;
        rf_write_data    <= wr_data_p0;
      end
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: a round-robin instance (u0) and a
// fixed-priority, drop-r0 instance (u1) share the same stimulus.
module tb_rf_write_arbiter;

  logic        clock;
  logic        reset;
  logic        wb_valid;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        ld_issue_valid;
  logic [2:0]  ld_issue_addr;
  logic        ld_valid;
  logic [2:0]  ld_addr;
  logic [15:0] ld_data;

  logic        wb_ready0, ld_issue_ready0, ld_ready0, en0;
  logic [7:0]  busy0;
  logic [2:0]  wa0;
  logic [15:0] wd0;
  logic        wb_ready1, ld_issue_ready1, ld_ready1, en1;
  logic [7:0]  busy1;
  logic [2:0]  wa1;
  logic [15:0] wd1;

  int n_chk  = 0;
  int n_fail = 0;

  rf_write_arbiter #(.DATA_W(16), .ADDR_W(3), .FIXED_PRIO(0), .DROP_R0(0)) u0 (
    .clock(clock), .reset(reset),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready0),
    .ld_issue_valid(ld_issue_valid), .ld_issue_addr(ld_issue_addr), .ld_issue_ready(ld_issue_ready0),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready0),
    .busy(busy0), .rf_write_en(en0), .rf_write_address(wa0), .rf_write_data(wd0)
  );

  rf_write_arbiter #(.DATA_W(16), .ADDR_W(3), .FIXED_PRIO(1), .DROP_R0(1)) u1 (
    .clock(clock), .reset(reset),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready1),
    .ld_issue_valid(ld_issue_valid), .ld_issue_addr(ld_issue_addr), .ld_issue_ready(ld_issue_ready1),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready1),
    .busy(busy1), .rf_write_en(en1), .rf_write_address(wa1), .rf_write_data(wd1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle;
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    ld_issue_valid = 1'b0; ld_issue_addr = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    #3;
    chk("rst_en",   {31'd0, en0}, 32'd0);
    chk("rst_addr", {29'd0, wa0}, 32'd0);
    chk("rst_data", {16'd0, wd0}, 32'd0);
    chk("rst_busy", {24'd0, busy0}, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Test 1: lone wb write
    wb_valid = 1'b1; wb_addr = 3'd3; wb_data = 16'h1234;
    #1;
    chk("t1_wb_ready0", {31'd0, wb_ready0}, 32'd1);
    chk("t1_wb_ready1", {31'd0, wb_ready1}, 32'd1);
    tick();
    idle();
    chk("t1_en",   {31'd0, en0}, 32'd1);
    chk("t1_addr", {29'd0, wa0}, 32'd3);
    chk("t1_data", {16'd0, wd0}, 32'h1234);

    // Test 2: both valid; u0 alternates starting with ld (last grant was wb), u1 always wb
    wb_valid = 1'b1; wb_addr = 3'd1; wb_data = 16'h1111;
    ld_valid = 1'b1; ld_addr = 3'd5; ld_data = 16'h5555;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t2_wb_ready0", {31'd0, wb_ready0}, (k % 2 == 0) ? 32'd0 : 32'd1);
      chk("t2_ld_ready0", {31'd0, ld_ready0}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("t2_wb_ready1", {31'd0, wb_ready1}, 32'd1);
      chk("t2_ld_ready1", {31'd0, ld_ready1}, 32'd0);
      tick();
      chk("t2_addr0", {29'd0, wa0}, (k % 2 == 0) ? 32'd5 : 32'd1);
      chk("t2_data0", {16'd0, wd0}, (k % 2 == 0) ? 32'h5555 : 32'h1111);
      chk("t2_addr1", {29'd0, wa1}, 32'd1);
      chk("t2_en1",   {31'd0, en1}, 32'd1);
    end
    idle();

    // Test 3: issue load to r2, return it
    ld_issue_valid = 1'b1; ld_issue_addr = 3'd2;
    #1;
    chk("t3_issue_ready", {31'd0, ld_issue_ready0}, 32'd1);
    tick();
    ld_issue_valid = 1'b0;
    #1;
    chk("t3_busy_pend", {24'd0, busy0}, 32'h04);
    chk("t3_issue_blocked", {31'd0, ld_issue_ready0}, 32'd0);
    ld_valid = 1'b1; ld_addr = 3'd2; ld_data = 16'hBEEF;
    #1;
    chk("t3_ld_ready", {31'd0, ld_ready0}, 32'd1);
    tick();
    idle();
    chk("t3_en",   {31'd0, en0}, 32'd1);
    chk("t3_addr", {29'd0, wa0}, 32'd2);
    chk("t3_data", {16'd0, wd0}, 32'hBEEF);
    chk("t3_busy_wr", {24'd0, busy0}, 32'h04);
    tick();
    chk("t3_busy_clr", {24'd0, busy0}, 32'h00);
    chk("t3_en_off", {31'd0, en0}, 32'd0);

    // Test 4: WAW - wb to r4 overtakes the outstanding load
    ld_issue_valid = 1'b1; ld_issue_addr = 3'd4;
    tick();
    idle();
    wb_valid = 1'b1; wb_addr = 3'd4; wb_data = 16'h0001;
    #1;
    chk("t4_wb_ready", {31'd0, wb_ready0}, 32'd1);
    tick();
    idle();
    chk("t4_wb_data", {16'd0, wd0}, 32'h0001);
    chk("t4_busy_killed", {24'd0, busy0}, 32'h10);
    ld_valid = 1'b1; ld_addr = 3'd4; ld_data = 16'hDEAD;
    #1;
    chk("t4_ld_ready", {31'd0, ld_ready0}, 32'd1);
    tick();
    idle();
    chk("t4_no_write", {31'd0, en0}, 32'd0);
    chk("t4_data_kept", {16'd0, wd0}, 32'h0001);
    chk("t4_busy_clr", {24'd0, busy0}, 32'h00);

    // Dropped load must not have moved the round-robin pointer: ld wins next conflict
    wb_valid = 1'b1; wb_addr = 3'd1; wb_data = 16'h1111;
    ld_valid = 1'b1; ld_addr = 3'd3; ld_data = 16'h3333;
    #1;
    chk("rr_ld_wins",  {31'd0, ld_ready0}, 32'd1);
    chk("rr_wb_loses", {31'd0, wb_ready0}, 32'd0);
    tick();
    idle();
    chk("rr_addr", {29'd0, wa0}, 32'd3);

    // Test 5: same-cycle wb and ld to pending r6
    ld_issue_valid = 1'b1; ld_issue_addr = 3'd6;
    tick();
    idle();
    wb_valid = 1'b1; wb_addr = 3'd6; wb_data = 16'hAAAA;
    ld_valid = 1'b1; ld_addr = 3'd6; ld_data = 16'h5A5A;
    #1;
    chk("t5_wb_ready", {31'd0, wb_ready0}, 32'd1);
    chk("t5_ld_ready", {31'd0, ld_ready0}, 32'd1);
    tick();
    idle();
    chk("t5_en",   {31'd0, en0}, 32'd1);
    chk("t5_data", {16'd0, wd0}, 32'hAAAA);
    chk("t5_busy", {24'd0, busy0}, 32'h00);
    tick();
    chk("t5_single", {31'd0, en0}, 32'd0);

    // r6 must not retain a stale kill: a fresh load to it is written
    ld_issue_valid = 1'b1; ld_issue_addr = 3'd6;
    tick();
    idle();
    ld_valid = 1'b1; ld_addr = 3'd6; ld_data = 16'h7777;
    tick();
    idle();
    chk("t5_reload_en",   {31'd0, en0}, 32'd1);
    chk("t5_reload_data", {16'd0, wd0}, 32'h7777);

    // Writes to r0: written by u0, suppressed by u1
    wb_valid = 1'b1; wb_addr = 3'd0; wb_data = 16'h00FF;
    tick();
    idle();
    chk("r0_en0", {31'd0, en0}, 32'd1);
    chk("r0_en1", {31'd0, en1}, 32'd0);

    // Test 6: fill every pending slot, write in flight, then asynchronous reset
    for (int i = 0; i < 8; i++) begin
      ld_issue_valid = 1'b1; ld_issue_addr = 3'(i);
      if (i == 7) begin
        wb_valid = 1'b1; wb_addr = 3'd1; wb_data = 16'h1357;
      end
      tick();
    end
    idle();
    chk("t6_busy_full", {24'd0, busy0}, 32'hFF);
    chk("t6_en_live",   {31'd0, en0}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_en",   {31'd0, en0}, 32'd0);
    chk("t6_rst_addr", {29'd0, wa0}, 32'd0);
    chk("t6_rst_data", {16'd0, wd0}, 32'd0);
    chk("t6_rst_busy", {24'd0, busy0}, 32'd0);
    #2;
    reset = 1'b0;
    tick();
    ld_valid = 1'b1; ld_addr = 3'd5; ld_data = 16'hC0DE;
    #1;
    chk("t6_post_ld_ready", {31'd0, ld_ready0}, 32'd1);
    tick();
    idle();
    chk("t6_post_en",   {31'd0, en0}, 32'd1);
    chk("t6_post_addr", {29'd0, wa0}, 32'd5);
    chk("t6_post_data", {16'd0, wd0}, 32'hC0DE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
